// File: rtl/count_bcd_pkg.sv
// Shared constants and helpers for the cascaded BCD counter.
package count_bcd_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam logic [3:0]  BCD_MIN    = 4'd0;
    localparam int unsigned DIGITS_DEF = 4;

    // Force an out-of-range BCD digit to 9 on load.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the cascade: next-value logic plus terminal-count ripple.
// An illegal digit (>9) is treated as terminal in both directions so it
// recovers to 0 (up) or 9 (down) on the next step.
module bcd_digit
    import count_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] q,
    input  logic             en,
    input  logic             dn,
    input  logic             ci,
    output logic [BCD_W-1:0] d,
    output logic             co
);

    logic term;

    // Step this digit when enabled and all lower digits are terminal.
    always_comb begin
        term = dn ? ((q == BCD_MIN) || (q > BCD_MAX)) : (q >= BCD_MAX);
        d    = q;
        if (en && ci) begin
            if (dn) begin
                d = term ? BCD_MAX : (q - 4'd1);
            end else begin
                d = term ? BCD_MIN : (q + 4'd1);
            end
        end
        co = term & ci;
    end

endmodule

// File: rtl/count_bcd_ndigit.sv
// N-digit up/down BCD counter with clear, clamped parallel load, sticky
// illegal-load flag and combinational terminal-count strobe.
// Define COUNT_BCD_SAT_EN to hold at all nines (up) / all zeros (down)
// instead of wrapping.
module count_bcd_ndigit
    import count_bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   ld_val,
    input  logic                  ena,
    input  logic                  dn,
    output logic [4*DIGITS-1:0]   q,
    output logic                  c_o,
    output logic                  err
);

    logic [4*DIGITS-1:0] q_q;
    logic [4*DIGITS-1:0] step_d;
    logic [4*DIGITS-1:0] clamp_d;
    logic [DIGITS:0]     carry;
    logic                err_q;
    logic                all_nine;
    logic                all_zero;
    logic                any_bad;
    logic                sat_hold;
    logic                unused_co;

    assign carry[0]  = 1'b1;
    assign unused_co = carry[DIGITS];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .q  (q_q[4*i +: 4]),
                .en (ena),
                .dn (dn),
                .ci (carry[i]),
                .d  (step_d[4*i +: 4]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // Whole-word terminal detection, load clamp and illegal-digit detection.
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        any_bad  = 1'b0;
        clamp_d  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (q_q[4*i +: 4] != BCD_MAX) all_nine = 1'b0;
            if (q_q[4*i +: 4] != BCD_MIN) all_zero = 1'b0;
            if (ld_val[4*i +: 4] > BCD_MAX) any_bad = 1'b1;
            clamp_d[4*i +: 4] = bcd_clamp(ld_val[4*i +: 4]);
        end
`ifdef COUNT_BCD_SAT_EN
        sat_hold = dn ? all_zero : all_nine;
`else
        sat_hold = 1'b0;
`endif
        // rst_n gating keeps the strobe quiet while the counter sits in reset.
        c_o = rst_n & ena & ~clr & ~ld & (dn ? all_zero : all_nine);
    end

    // Count register and sticky error flag; priority clr > ld > ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else if (clr) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else if (ld) begin
            q_q <= clamp_d;
            if (any_bad) err_q <= 1'b1;
        end else if (ena && !sat_hold) begin
            q_q <= step_d;
        end
    end

    assign q   = q_q;
    assign err = err_q;

endmodule

// File: tb/tb_count_bcd_ndigit.sv
// Directed bench for count_bcd_ndigit: vector table plus hand sequences for
// reset, illegal load, 1/8-digit instances and a full 10000-step up sweep.
module tb_count_bcd_ndigit;

`ifdef COUNT_BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, clr, ld, ena, dn;
    logic [15:0] ld_val4;
    logic [3:0]  ld_val1;
    logic [31:0] ld_val8;
    logic [15:0] q4;
    logic [3:0]  q1;
    logic [31:0] q8;
    logic        co4, co1, co8, err4, err1, err8;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    count_bcd_ndigit #(.DIGITS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .ld_val(ld_val4),
        .ena(ena), .dn(dn), .q(q4), .c_o(co4), .err(err4)
    );

    count_bcd_ndigit #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .ld_val(ld_val1),
        .ena(ena), .dn(dn), .q(q1), .c_o(co1), .err(err1)
    );

    count_bcd_ndigit #(.DIGITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .ld_val(ld_val8),
        .ena(ena), .dn(dn), .q(q8), .c_o(co8), .err(err8)
    );

    typedef struct {
        logic        clr;
        logic        ld;
        logic        ena;
        logic        dn;
        logic [15:0] ld_val;
        logic        exp_co;
        logic [15:0] exp_q;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    initial begin
        logic [15:0] wrap_up, wrap_dn;
        int cnt, pulses;

        wrap_up = SAT ? 16'h9999 : 16'h0000;
        wrap_dn = SAT ? 16'h0000 : 16'h9999;

        rst_n = 1'b0; clr = 1'b0; ld = 1'b0; ena = 1'b0; dn = 1'b0;
        ld_val4 = '0; ld_val1 = '0; ld_val8 = '0;

        //             clr ld ena dn  ld_val    co  q         err
        vecs.push_back('{0, 1, 0, 0, 16'h0999, 0, 16'h0999, 0});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 0, 16'h1000, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h1000, 0, 16'h1000, 0});
        vecs.push_back('{0, 0, 1, 1, 16'h0000, 0, 16'h0999, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h9999, 0, 16'h9999, 0});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 1, wrap_up,  0});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 1, 1, 16'h0000, 1, wrap_dn,  0});
        vecs.push_back('{1, 1, 1, 0, 16'h1234, 0, 16'h0000, 0});
        vecs.push_back('{0, 1, 1, 1, 16'h1234, 0, 16'h1234, 0});
        vecs.push_back('{0, 0, 1, 1, 16'h0000, 0, 16'h1233, 0});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 0, 16'h1234, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 16'h1234, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h0250, 0, 16'h0250, 0});
        vecs.push_back('{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0});
        vecs.push_back('{0, 1, 1, 0, 16'h3C5F, 0, 16'h3959, 1});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 0, 16'h3960, 1});
        vecs.push_back('{1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0});

        // Reset state, with dn=1 and ena=1 so c_o gating by rst_n is visible.
        #2;
        ena = 1'b1; dn = 1'b1;
        #1;
        chk("reset_q", 32'(q4), 32'h0);
        chk("reset_err", 32'(err4), 32'h0);
        chk("reset_co", 32'(co4), 32'h0);
        ena = 1'b0; dn = 1'b0;
        tick();
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            clr = vecs[i].clr; ld = vecs[i].ld; ena = vecs[i].ena; dn = vecs[i].dn;
            ld_val4 = vecs[i].ld_val;
            #2;
            chk($sformatf("vec%0d_co", i), 32'(co4), 32'(vecs[i].exp_co));
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q4), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_err", i), 32'(err4), 32'(vecs[i].exp_err));
        end

        // Illegal load: err persists through 20 up counts, clears on clr.
        clr = 1'b0; ld = 1'b1; ena = 1'b0; dn = 1'b0; ld_val4 = 16'h3C5F;
        tick();
        chk("illegal_ld_q", 32'(q4), 32'h3959);
        ld = 1'b0; ena = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("illegal_20_q", 32'(q4), 32'h3979);
        chk("illegal_20_err", 32'(err4), 32'h1);
        ena = 1'b0; clr = 1'b1;
        tick();
        chk("illegal_clr_err", 32'(err4), 32'h0);
        chk("illegal_clr_q", 32'(q4), 32'h0);
        clr = 1'b0;

        // Async reset mid-count at 0x0417 with err set.
        ld = 1'b1; ld_val4 = 16'hF000;
        tick();
        ld_val4 = 16'h0415;
        tick();
        ld = 1'b0; ena = 1'b1;
        tick();
        tick();
        chk("pre_rst_q", 32'(q4), 32'h0417);
        chk("pre_rst_err", 32'(err4), 32'h1);
        #2;
        rst_n = 1'b0; dn = 1'b1;
        #1;
        chk("async_rst_q", 32'(q4), 32'h0);
        chk("async_rst_err", 32'(err4), 32'h0);
        chk("async_rst_co", 32'(co4), 32'h0);
        tick();
        chk("rst_held_q", 32'(q4), 32'h0);
        rst_n = 1'b1; dn = 1'b0;
        tick();
        chk("rst_resume_q", 32'(q4), 32'h0001);

        // 1-digit and 8-digit spot checks.
        ena = 1'b0; ld = 1'b1; ld_val1 = 4'h9; ld_val8 = 32'h0999_9999;
        tick();
        ld = 1'b0; ena = 1'b1; dn = 1'b0;
        #2;
        chk("d1_up_co", 32'(co1), 32'h1);
        chk("d8_up_co", 32'(co8), 32'h0);
        tick();
        chk("d1_up_q", 32'(q1), SAT ? 32'h9 : 32'h0);
        chk("d8_ripple_q", q8, 32'h1000_0000);
        ena = 1'b0; ld = 1'b1; ld_val1 = 4'hC; ld_val8 = 32'h9999_9999;
        tick();
        chk("d1_clamp_q", 32'(q1), 32'h9);
        chk("d1_clamp_err", 32'(err1), 32'h1);
        ld = 1'b0; ena = 1'b1;
        #2;
        chk("d8_nines_co", 32'(co8), 32'h1);
        tick();
        chk("d8_wrap_up_q", q8, SAT ? 32'h9999_9999 : 32'h0);
        ena = 1'b0; ld = 1'b1; ld_val8 = 32'h0;
        tick();
        ld = 1'b0; ena = 1'b1; dn = 1'b1;
        #2;
        chk("d8_zeros_co", 32'(co8), 32'h1);
        tick();
        chk("d8_wrap_dn_q", q8, SAT ? 32'h0 : 32'h9999_9999);

        // Full up sweep against a decimal model.
        ena = 1'b0; dn = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; ena = 1'b1;
        cnt = 0;
        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            #2;
            if (co4) pulses++;
            if (co4 !== (cnt == 9999)) chk($sformatf("sweep_co_%0d", cnt), 32'(co4), 32'(cnt == 9999));
            tick();
            cnt = (cnt == 9999) ? (SAT ? 9999 : 0) : cnt + 1;
            chk($sformatf("sweep_q_%0d", i), 32'(q4), 32'(to_bcd(cnt)));
        end
        chk("sweep_pulses", 32'(pulses), 32'd1);
        ena = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/count_bcd_ndigit.md
COUNT_BCD_NDIGIT -- requirements
Module: count_bcd_ndigit

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous clear of count.
REQ-005 ld  input  1  synchronous parallel load of ld_val.
REQ-006 ld_val  input  4*DIGITS  load value; digit i at bits [4i+3:4i].
REQ-007 ena  input  1  count enable.
REQ-008 dn  input  1  direction: 0 = up, 1 = down.
REQ-009 q  output  4*DIGITS  registered count; digit 0 least significant.
REQ-010 c_o  output  1  combinational terminal-count strobe (carry up / borrow down).
REQ-011 err  output  1  registered sticky flag: illegal BCD digit seen on load.

Function
REQ-012 Per-edge priority SHALL be clr > ld > ena; with none asserted, q holds.
REQ-013 clr SHALL set q to all zeros and clear err on the next edge.
REQ-014 ld SHALL write ld_val to q on the next edge; any digit > 9 SHALL be written as 9.
REQ-015 ld with any digit > 9 SHALL set err on the same edge; err stays set until clr or reset.
REQ-016 Up count: digit 0 SHALL increment by one; digit i SHALL step only when all digits below i equal 9; 9 -> 0 wraps per digit.
REQ-017 Down count: digit 0 SHALL decrement by one; digit i SHALL step only when all digits below i equal 0; 0 -> 9 wraps per digit.
REQ-018 c_o SHALL equal ena & ~clr & ~ld & (dn ? q all zeros : q all nines), within the same cycle, zero latency.
REQ-019 At terminal count without saturation, up SHALL wrap all nines -> all zeros and down SHALL wrap all zeros -> all nines.
REQ-020 If q holds an illegal digit (unreachable in normal use), the next count step SHALL load that digit as 0 (up) or 9 (down), treating it as terminal for ripple.
REQ-021 dn SHALL be sampled every cycle; a direction change SHALL take effect on the edge it is sampled with, with no extra latency.

Reset
REQ-022 rst_n low SHALL immediately force q = 0 and err = 0, independent of clk.
REQ-023 c_o SHALL read 0 while rst_n is low.
REQ-024 Deassertion of rst_n mid-operation SHALL resume counting from 0 on the first rising edge with rst_n high.

Configuration
REQ-025 Macro COUNT_BCD_SAT_EN SHALL select saturating mode.
REQ-026 With COUNT_BCD_SAT_EN defined: at all nines counting up, or all zeros counting down, q SHALL hold and c_o SHALL remain asserted every enabled cycle.
REQ-027 Without COUNT_BCD_SAT_EN: wrap behaviour per REQ-019; c_o is a one-cycle strobe per terminal crossing.

Structure
REQ-028 Shared package count_bcd_pkg SHALL hold BCD_W = 4, BCD_MAX = 4'd9, BCD_MIN = 4'd0 and the DIGITS default.
REQ-029 Sub-module bcd_digit SHALL implement one digit: inputs q, en, dn, ci (lower digits terminal); outputs next digit and co (this digit terminal and ci).
REQ-030 count_bcd_ndigit SHALL instantiate DIGITS bcd_digit cells in a generate loop chaining co -> ci; registers, load clamp, err and c_o are in the top.

Verification
REQ-031 Reset/clear: rst_n low mid-count at q=0x0417 -> q=0x0000 and err=0 immediately; clr at q=0x0250 -> q=0x0000 next edge.
REQ-032 Up ripple (DIGITS=4): ld 0x0999, then ena, dn=0 -> q=0x1000; from 0x9999 -> c_o=1 that cycle, q=0x0000 next (0x9999 held if SAT).
REQ-033 Down ripple: ld 0x1000, ena, dn=1 -> 0x0999; from 0x0000 -> c_o=1, q=0x9999 next (0x0000 held if SAT).
REQ-034 Priority: clr=ld=ena=1 with ld_val=0x1234 -> q=0x0000; ld=ena=1 -> q=0x1234, c_o=0.
REQ-035 Illegal load: ld_val=0x3C5F -> q=0x3959, err=1; err persists through 20 counts, clears on clr.
REQ-036 Exhaustive: 10000 up counts from 0x0000 compared against decimal reference model, exactly one c_o pulse; repeat with DIGITS=1 and DIGITS=8 spot checks.
